// File: rtl/hatch_sequencer.sv
// ---------------------------------------------------------------------------
// hatch_sequencer
//
// Timing and state controller for the egg-hatching dot-matrix display path.
// While the incubator temperature is good it steps the display stage index
// `num` from 0 up to LAST_STAGE, spending STAGE_TICKS clock cycles on each
// stage. A cold incubator freezes progress without losing elapsed stage
// time. If the cold spell lasts too long the sequencer gives up, and the
// display enable blinks so the failure is visible on the panel.
//
// Ports:
//   clk    in   1  1 kHz display clock, all logic on the rising edge
//   rst    in   1  synchronous active-low reset
//   start  in   1  one-cycle start / restart request (IDLE, DONE, FAIL)
//   abort  in   1  one-cycle abort request, returns to IDLE from any state
//   temp   in   1  1 = temperature in range, 0 = cold
//   num    out  4  stage index for the display block (0..LAST_STAGE)
//   st     out  1  display enable for the display block
//   busy   out  1  high while running or holding
//   done   out  1  high once the final stage has been reached
//   fail   out  1  high after a sustained cold period
// ---------------------------------------------------------------------------
module hatch_sequencer #(
    parameter int STAGE_TICKS = 1000,  // cycles per stage while warm, 1..65535
    parameter int LAST_STAGE  = 11,    // final stage index, 1..15
    parameter int COLD_LIMIT  = 5000,  // cold cycles in HOLD before failing, 1..65535
    parameter int BLINK_TICKS = 250    // half-period of the failure blink, 1..65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       temp,
    output logic [3:0] num,
    output logic       st,
    output logic       busy,
    output logic       done,
    output logic       fail
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_HOLD = 3'd2,
        S_DONE = 3'd3,
        S_FAIL = 3'd4
    } state_t;

    // Terminal counts, sized to the 16-bit counters they are compared with.
    localparam logic [15:0] TICK_LAST  = 16'(STAGE_TICKS - 1);
    localparam logic [15:0] COLD_LAST  = 16'(COLD_LIMIT - 1);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_TICKS - 1);
    // The stage just before the final one: advancing out of it finishes.
    localparam logic [3:0]  STAGE_PRE  = 4'(LAST_STAGE - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] tick_cnt;
    logic [15:0] tick_next;
    logic [15:0] cold_cnt;
    logic [15:0] cold_next;
    logic [15:0] blink_cnt;
    logic [15:0] blink_next;
    logic [3:0]  num_next;
    logic        st_next;

    // -----------------------------------------------------------------------
    // State and output registers. Every register, data included, is cleared
    // by reset so the display path starts from a known blank picture.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            tick_cnt  <= 16'd0;
            cold_cnt  <= 16'd0;
            blink_cnt <= 16'd0;
            num       <= 4'd0;
            st        <= 1'b0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_next;
            cold_cnt  <= cold_next;
            blink_cnt <= blink_next;
            num       <= num_next;
            st        <= st_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic. Everything holds by default; abort
    // takes priority over any state-specific decision.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        cold_next  = cold_cnt;
        blink_next = blink_cnt;
        num_next   = num;
        st_next    = st;

        if (abort) begin
            state_next = S_IDLE;
            tick_next  = 16'd0;
            cold_next  = 16'd0;
            blink_next = 16'd0;
            num_next   = 4'd0;
            st_next    = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // temp is irrelevant until a run has been requested.
                    if (start) begin
                        state_next = S_RUN;
                        tick_next  = 16'd0;
                        num_next   = 4'd0;
                        st_next    = 1'b1;
                    end
                end

                S_RUN: begin
                    st_next = 1'b1;
                    if (!temp) begin
                        // Cold takes precedence over a stage boundary: the
                        // tick and stage are frozen exactly where they are.
                        state_next = S_HOLD;
                        cold_next  = 16'd0;
                    end else if (tick_cnt == TICK_LAST) begin
                        tick_next = 16'd0;
                        num_next  = num + 4'd1;
                        if (num == STAGE_PRE) begin
                            state_next = S_DONE;
                        end
                    end else begin
                        tick_next = tick_cnt + 16'd1;
                    end
                end

                S_HOLD: begin
                    st_next = 1'b1;
                    if (temp) begin
                        // tick_cnt was never touched in HOLD, so the stage
                        // picks up where it left off.
                        state_next = S_RUN;
                    end else if (cold_cnt == COLD_LAST) begin
                        state_next = S_FAIL;
                        blink_next = 16'd0;
                        st_next    = 1'b0;
                    end else begin
                        cold_next = cold_cnt + 16'd1;
                    end
                end

                S_DONE: begin
                    st_next = 1'b1;
                    if (start) begin
                        state_next = S_RUN;
                        tick_next  = 16'd0;
                        num_next   = 4'd0;
                    end
                end

                S_FAIL: begin
                    if (start) begin
                        state_next = S_RUN;
                        tick_next  = 16'd0;
                        num_next   = 4'd0;
                        st_next    = 1'b1;
                    end else if (blink_cnt == BLINK_LAST) begin
                        // num stays frozen at the stage that failed.
                        blink_next = 16'd0;
                        st_next    = ~st;
                    end else begin
                        blink_next = blink_cnt + 16'd1;
                    end
                end

                default: begin
                    state_next = S_IDLE;
                    tick_next  = 16'd0;
                    cold_next  = 16'd0;
                    blink_next = 16'd0;
                    num_next   = 4'd0;
                    st_next    = 1'b0;
                end
            endcase
        end
    end

    // Status flags are pure decodes of the state register, so they change
    // on the same edge as num and st.
    assign busy = (state == S_RUN) || (state == S_HOLD);
    assign done = (state == S_DONE);
    assign fail = (state == S_FAIL);

endmodule

// File: tb/tb_hatch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hatch_sequencer
//
// Bench for hatch_sequencer with small timing parameters. A reference model
// tracks the hatch as "total warm ticks of progress", "length of the current
// cold streak" and "age of the failure", and derives the displayed outputs
// from those with plain arithmetic. Directed vectors, hand-written corner
// sequences and a randomized run all go through the same step task.
// ---------------------------------------------------------------------------
module tb_hatch_sequencer;

    localparam int ST = 4;   // STAGE_TICKS
    localparam int LS = 11;  // LAST_STAGE
    localparam int CL = 6;   // COLD_LIMIT
    localparam int BT = 2;   // BLINK_TICKS

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       temp  = 1'b0;
    logic [3:0] num;
    logic       st;
    logic       busy;
    logic       done;
    logic       fail;

    hatch_sequencer #(
        .STAGE_TICKS(ST),
        .LAST_STAGE (LS),
        .COLD_LIMIT (CL),
        .BLINK_TICKS(BT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .abort(abort),
        .temp (temp),
        .num  (num),
        .st   (st),
        .busy (busy),
        .done (done),
        .fail (fail)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // ---------------- reference model ----------------
    localparam int P_IDLE = 0;
    localparam int P_WARM = 1;  // running
    localparam int P_COLD = 2;  // holding
    localparam int P_HATCHED = 3;
    localparam int P_DEAD = 4;

    int m_phase    = P_IDLE;
    int m_progress = 0;  // warm ticks accumulated since the run started
    int m_streak   = 0;  // consecutive cold edges, counting the one that left RUN
    int m_age      = 0;  // edges since failure was declared

    task automatic model_edge(input logic r, input logic s, input logic a, input logic t);
        if (!r || a) begin
            m_phase = P_IDLE; m_progress = 0; m_streak = 0; m_age = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (s) begin m_phase = P_WARM; m_progress = 0; end
                P_WARM: begin
                    if (!t) begin
                        m_phase = P_COLD; m_streak = 1;
                    end else begin
                        m_progress++;
                        if (m_progress == LS * ST) m_phase = P_HATCHED;
                    end
                end
                P_COLD: begin
                    if (t) begin
                        m_phase = P_WARM; m_streak = 0;
                    end else begin
                        m_streak++;
                        if (m_streak == CL + 1) begin m_phase = P_DEAD; m_age = 0; end
                    end
                end
                P_HATCHED: if (s) begin m_phase = P_WARM; m_progress = 0; end
                default: begin
                    if (s) begin m_phase = P_WARM; m_progress = 0; end
                    else m_age++;
                end
            endcase
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] n;
        logic       s;
        n = (m_phase == P_IDLE) ? 4'd0 : 4'(m_progress / ST);
        if (m_phase == P_IDLE) s = 1'b0;
        else if (m_phase == P_DEAD) s = ((m_age / BT) % 2) == 1;
        else s = 1'b1;
        return {n, s, (m_phase == P_WARM) || (m_phase == P_COLD),
                m_phase == P_HATCHED, m_phase == P_DEAD};
    endfunction

    function automatic logic [7:0] dut_out();
        return {num, st, busy, done, fail};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got num=%0d st/busy/done/fail=%b, expected num=%0d st/busy/done/fail=%b",
                     name, got[7:4], got[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    // Drive one set of inputs, take one rising edge, compare to the model.
    task automatic step(input logic r, input logic s, input logic a, input logic t);
        rst = r; start = s; abort = a; temp = t;
        @(posedge clk);
        model_edge(r, s, a, t);
        #1;
        check("model", dut_out(), model_out());
    endtask

    // Expected-output constructor for the hand-written checks.
    function automatic logic [7:0] o(input int n, input logic s, input logic b,
                                     input logic d, input logic f);
        return {4'(n), s, b, d, f};
    endfunction

    typedef struct {
        logic r, s, a, t;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // ---------------- directed vector table ----------------
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00};            // reset
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00};            // idle, no start
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00};            // start+abort: abort wins
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, {4'd0, 4'b1100}};  // RUN entry
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, {4'd0, 4'b1100}};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, {4'd0, 4'b1100}};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, {4'd0, 4'b1100}};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, {4'd1, 4'b1100}};  // 4 edges after entry
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, {4'd1, 4'b1100}};  // start ignored in RUN
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, {4'd1, 4'b1100}};  // HOLD
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, {4'd1, 4'b1100}};  // back to RUN
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, {4'd1, 4'b1100}};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, {4'd1, 4'b1100}};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, {4'd2, 4'b1100}};  // held time not lost
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00};            // abort mid-RUN (set below)
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, {4'd0, 4'b1100}};  // start with temp=0
        vecs[14].a = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].t);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // ---------------- 1: full run to DONE ----------------
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_state", dut_out(), 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("run_entry", dut_out(), o(0, 1, 1, 0, 0));
        for (int k = 1; k <= LS * ST; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            if (k % ST == 0 && k < LS * ST)
                check($sformatf("stage_step_%0d", k), dut_out(), o(k / ST, 1, 1, 0, 0));
        end
        check("done_at_44", dut_out(), o(LS, 1, 0, 1, 0));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("done_holds", dut_out(), o(LS, 1, 0, 1, 0));

        // ---------------- 4a + 2: restart from DONE, hold mid-stage ----------------
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("restart_from_done", dut_out(), o(0, 1, 1, 0, 0));
        for (int k = 0; k < 3 * ST + 2; k++) step(1'b1, 1'b0, 1'b0, 1'b1);  // num=3, tick=2
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check("hold_num_frozen", dut_out(), o(3, 1, 1, 0, 0));
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("hold_return", dut_out(), o(3, 1, 1, 0, 0));
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("hold_return_plus1", dut_out(), o(3, 1, 1, 0, 0));
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("hold_return_plus2", dut_out(), o(4, 1, 1, 0, 0));

        // ---------------- 3: sustained cold leads to failure ----------------
        for (int k = 0; k < ST; k++) step(1'b1, 1'b0, 1'b0, 1'b1);        // num=5
        for (int k = 1; k <= CL; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check("cold_not_yet", dut_out(), o(5, 1, 1, 0, 0));
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("fail_entry", dut_out(), o(5, 0, 0, 0, 1));
        for (int a = 1; a <= 5; a++) begin
            step(1'b1, 1'b0, 1'b0, 1'(a % 2));
            check($sformatf("blink_age%0d", a), dut_out(), o(5, ((a / BT) % 2) == 1, 0, 0, 1));
        end

        // ---------------- 4b: restart from FAIL, start ignored in RUN ----------------
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("restart_from_fail", dut_out(), o(0, 1, 1, 0, 0));
        for (int k = 0; k < ST - 1; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("start_in_run", dut_out(), o(1, 1, 1, 0, 0));

        // ---------------- 5: abort mid-RUN at num=7 ----------------
        for (int k = 0; k < 6 * ST; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
        check("reach_num7", dut_out(), o(7, 1, 1, 0, 0));
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("abort_run", dut_out(), 8'h00);

        // ---------------- 6: reset mid-HOLD ----------------
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("in_hold", dut_out(), o(0, 1, 1, 0, 0));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_hold", dut_out(), 8'h00);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'(k % 2));
            check("idle_after_rst", dut_out(), 8'h00);
        end

        // ---------------- randomized run against the model ----------------
        for (int k = 0; k < 4000; k++) begin
            logic r, s, a, t;
            bit   cold_spell;
            cold_spell = ((k / 64) % 3) == 2;
            r = ($urandom_range(0, 299) != 0);
            a = ($urandom_range(0, 149) == 0);
            s = ($urandom_range(0, 24) == 0);
            t = cold_spell ? ($urandom_range(0, 99) < 15) : ($urandom_range(0, 99) < 93);
            step(r, s, a, t);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
